// File: rtl/itcm_ctrl.sv
// ITCM controller: arbitrates the IFU fetch port and the LSU load/store port
// onto one single-port SRAM. LSU has priority, and responses come back one cycle after the command.
module itcm_ctrl #(
    parameter int AW = 16,
    parameter int DW = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              ifu_cmd_valid,
    output logic              ifu_cmd_ready,
    input  logic [AW-1:0]     ifu_cmd_addr,
    output logic              ifu_rsp_valid,
    input  logic              ifu_rsp_ready,
    output logic [DW-1:0]     ifu_rsp_rdata,
    output logic              ifu_rsp_err,

    input  logic              lsu_cmd_valid,
    output logic              lsu_cmd_ready,
    input  logic [AW-1:0]     lsu_cmd_addr,
    input  logic              lsu_cmd_read,
    input  logic [DW-1:0]     lsu_cmd_wdata,
    input  logic [DW/8-1:0]   lsu_cmd_wmask,
    output logic              lsu_rsp_valid,
    input  logic              lsu_rsp_ready,
    output logic [DW-1:0]     lsu_rsp_rdata,
    output logic              lsu_rsp_err,

    output logic              ram_cs,
    output logic              ram_we,
    output logic [AW-3:0]     ram_addr,
    output logic [DW/8-1:0]   ram_wem,
    output logic [DW-1:0]     ram_din,
    input  logic [DW-1:0]     ram_dout,

    output logic              itcm_nohold
);

    localparam int MW = DW / 8;

    logic          lsu_rsp_valid_q;
    logic          lsu_first_q;
    logic [DW-1:0] lsu_hold_q;
    logic          ifu_rsp_valid_q;
    logic          ifu_first_q;
    logic          ifu_err_q;
    logic [DW-1:0] ifu_hold_q;
    logic          nohold_q;

    logic ifu_grant;
    logic lsu_acc;
    logic ifu_acc;
    logic ifu_aligned;
    logic lsu_write;

    // LSU word accesses ignore the byte offset bits.
    logic unused_lsu_addr_lo;
    assign unused_lsu_addr_lo = &{1'b0, lsu_cmd_addr[1:0]};

    // rsp_ready only reaches the SRAM strobe through cmd_ready.
    assign lsu_cmd_ready = !lsu_rsp_valid_q || lsu_rsp_ready;
    assign ifu_grant     = !lsu_cmd_valid || !lsu_cmd_ready;
    assign ifu_cmd_ready = ifu_grant && (!ifu_rsp_valid_q || ifu_rsp_ready);

    assign lsu_acc     = lsu_cmd_valid && lsu_cmd_ready;
    assign ifu_acc     = ifu_cmd_valid && ifu_cmd_ready;
    assign ifu_aligned = (ifu_cmd_addr[1:0] == 2'b00);
    assign lsu_write   = lsu_acc && !lsu_cmd_read;

    assign ram_cs   = lsu_acc || (ifu_acc && ifu_aligned);
    assign ram_we   = lsu_write;
    assign ram_addr = lsu_acc ? lsu_cmd_addr[AW-1:2] : ifu_cmd_addr[AW-1:2];
    assign ram_wem  = lsu_write ? lsu_cmd_wmask : {MW{1'b0}};
    assign ram_din  = lsu_cmd_wdata;

    // SRAM data is live only in the first response cycle; after that the held copy is shown.
    assign ifu_rsp_valid = ifu_rsp_valid_q;
    assign ifu_rsp_rdata = ifu_first_q ? ram_dout : ifu_hold_q;
    assign ifu_rsp_err   = ifu_err_q;
    assign lsu_rsp_valid = lsu_rsp_valid_q;
    assign lsu_rsp_rdata = lsu_first_q ? ram_dout : lsu_hold_q;
    assign lsu_rsp_err   = 1'b0;
    assign itcm_nohold   = nohold_q;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            lsu_rsp_valid_q <= 1'b0;
            lsu_first_q     <= 1'b0;
            lsu_hold_q      <= '0;
            ifu_rsp_valid_q <= 1'b0;
            ifu_first_q     <= 1'b0;
            ifu_err_q       <= 1'b0;
            ifu_hold_q      <= '0;
            nohold_q        <= 1'b1;
        end else begin
            lsu_first_q <= lsu_acc && lsu_cmd_read;
            if (lsu_acc) begin
                lsu_rsp_valid_q <= 1'b1;
            end else if (lsu_rsp_valid_q && lsu_rsp_ready) begin
                lsu_rsp_valid_q <= 1'b0;
            end
            if (lsu_write) begin
                lsu_hold_q <= '0;
            end else if (lsu_first_q) begin
                lsu_hold_q <= ram_dout;
            end

            ifu_first_q <= ifu_acc && ifu_aligned;
            if (ifu_acc) begin
                ifu_rsp_valid_q <= 1'b1;
                ifu_err_q       <= !ifu_aligned;
            end else if (ifu_rsp_valid_q && ifu_rsp_ready) begin
                ifu_rsp_valid_q <= 1'b0;
                ifu_err_q       <= 1'b0;
            end
            if (ifu_acc && !ifu_aligned) begin
                ifu_hold_q <= '0;
            end else if (ifu_first_q) begin
                ifu_hold_q <= ram_dout;
            end

            if (lsu_acc) begin
                nohold_q <= 1'b1;
            end else if (ifu_acc && ifu_aligned) begin
                nohold_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_itcm_ctrl.sv
// Self-checking bench for itcm_ctrl: a transaction-level model predicts handshakes,
// SRAM strobes and response data every cycle, while directed scenarios pin literal values.
module tb_itcm_ctrl;

    localparam int AW    = 16;
    localparam int DW    = 32;
    localparam int MW    = DW / 8;
    localparam int WORDS = 1 << (AW - 2);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ifu_cmd_valid = 1'b0;
    logic          ifu_cmd_ready;
    logic [AW-1:0] ifu_cmd_addr = '0;
    logic          ifu_rsp_valid;
    logic          ifu_rsp_ready = 1'b0;
    logic [DW-1:0] ifu_rsp_rdata;
    logic          ifu_rsp_err;
    logic          lsu_cmd_valid = 1'b0;
    logic          lsu_cmd_ready;
    logic [AW-1:0] lsu_cmd_addr = '0;
    logic          lsu_cmd_read = 1'b1;
    logic [DW-1:0] lsu_cmd_wdata = '0;
    logic [MW-1:0] lsu_cmd_wmask = '0;
    logic          lsu_rsp_valid;
    logic          lsu_rsp_ready = 1'b0;
    logic [DW-1:0] lsu_rsp_rdata;
    logic          lsu_rsp_err;
    logic          ram_cs;
    logic          ram_we;
    logic [AW-3:0] ram_addr;
    logic [MW-1:0] ram_wem;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout = '0;
    logic          itcm_nohold;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    itcm_ctrl #(.AW(AW), .DW(DW)) dut (
        .clk           (clk),
        .rst           (rst),
        .ifu_cmd_valid (ifu_cmd_valid),
        .ifu_cmd_ready (ifu_cmd_ready),
        .ifu_cmd_addr  (ifu_cmd_addr),
        .ifu_rsp_valid (ifu_rsp_valid),
        .ifu_rsp_ready (ifu_rsp_ready),
        .ifu_rsp_rdata (ifu_rsp_rdata),
        .ifu_rsp_err   (ifu_rsp_err),
        .lsu_cmd_valid (lsu_cmd_valid),
        .lsu_cmd_ready (lsu_cmd_ready),
        .lsu_cmd_addr  (lsu_cmd_addr),
        .lsu_cmd_read  (lsu_cmd_read),
        .lsu_cmd_wdata (lsu_cmd_wdata),
        .lsu_cmd_wmask (lsu_cmd_wmask),
        .lsu_rsp_valid (lsu_rsp_valid),
        .lsu_rsp_ready (lsu_rsp_ready),
        .lsu_rsp_rdata (lsu_rsp_rdata),
        .lsu_rsp_err   (lsu_rsp_err),
        .ram_cs        (ram_cs),
        .ram_we        (ram_we),
        .ram_addr      (ram_addr),
        .ram_wem       (ram_wem),
        .ram_din       (ram_din),
        .ram_dout      (ram_dout),
        .itcm_nohold   (itcm_nohold)
    );

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Power-on contents: word i holds 0x1000_0000 + 4*i (its own byte address).
    function automatic logic [DW-1:0] init_word(input int i);
        return 32'h1000_0000 + DW'(i * 4);
    endfunction

    // SRAM behaviour: registered read, masked write, untouched words read their power-on value.
    logic [DW-1:0] sram [WORDS];
    bit            sram_written [WORDS];
    logic [DW-1:0] sram_cur;
    always @(posedge clk) begin
        if (ram_cs) begin
            sram_cur = sram_written[ram_addr] ? sram[ram_addr] : init_word(int'(ram_addr));
            if (ram_we) begin
                for (int b = 0; b < MW; b++) begin
                    if (ram_wem[b]) sram_cur[8*b +: 8] = ram_din[8*b +: 8];
                end
                sram[ram_addr]         <= sram_cur;
                sram_written[ram_addr] <= 1'b1;
            end else begin
                ram_dout <= sram_cur;
            end
        end
    end

    // Transaction-level reference: one outstanding response per port with its final data.
    logic [DW-1:0] golden [WORDS];
    bit            m_ifu_v, m_ifu_err, m_lsu_v, m_nohold;
    logic [DW-1:0] m_ifu_d, m_lsu_d;

    initial begin
        bit e_lrdy, e_irdy, l_acc, i_acc, i_al, e_cs, e_we;
        int w;
        for (int i = 0; i < WORDS; i++) golden[i] = init_word(i);
        m_ifu_v = 0; m_ifu_err = 0; m_lsu_v = 0; m_nohold = 1;
        m_ifu_d = '0; m_lsu_d = '0;
        wait (rst);
        @(posedge clk);
        forever begin
            @(negedge clk);
            e_lrdy = !m_lsu_v || lsu_rsp_ready;
            e_irdy = (!lsu_cmd_valid || !e_lrdy) && (!m_ifu_v || ifu_rsp_ready);
            l_acc  = lsu_cmd_valid && e_lrdy;
            i_acc  = ifu_cmd_valid && e_irdy;
            i_al   = (ifu_cmd_addr % 4) == 0;
            e_cs   = l_acc || (i_acc && i_al);
            e_we   = l_acc && !lsu_cmd_read;

            check("m_lsu_cmd_ready", lsu_cmd_ready, e_lrdy);
            check("m_ifu_cmd_ready", ifu_cmd_ready, e_irdy);
            check("m_ram_cs", ram_cs, e_cs);
            if (e_cs) begin
                check("m_ram_addr", ram_addr, l_acc ? lsu_cmd_addr / 4 : ifu_cmd_addr / 4);
                check("m_ram_we", ram_we, e_we);
                check("m_ram_wem", ram_wem, e_we ? lsu_cmd_wmask : '0);
                if (e_we) check("m_ram_din", ram_din, lsu_cmd_wdata);
            end
            check("m_ifu_rsp_valid", ifu_rsp_valid, m_ifu_v);
            if (m_ifu_v) begin
                check("m_ifu_rsp_rdata", ifu_rsp_rdata, m_ifu_d);
                check("m_ifu_rsp_err", ifu_rsp_err, m_ifu_err);
            end
            check("m_lsu_rsp_valid", lsu_rsp_valid, m_lsu_v);
            if (m_lsu_v) begin
                check("m_lsu_rsp_rdata", lsu_rsp_rdata, m_lsu_d);
                check("m_lsu_rsp_err", lsu_rsp_err, 1'b0);
            end
            check("m_itcm_nohold", itcm_nohold, m_nohold);

            if (rst) begin
                m_ifu_v = 0; m_ifu_err = 0; m_lsu_v = 0; m_nohold = 1;
            end else begin
                if (l_acc) begin
                    w = int'(lsu_cmd_addr / 4);
                    if (lsu_cmd_read) begin
                        m_lsu_d = golden[w];
                    end else begin
                        for (int b = 0; b < MW; b++) begin
                            if (lsu_cmd_wmask[b]) golden[w][8*b +: 8] = lsu_cmd_wdata[8*b +: 8];
                        end
                        m_lsu_d = '0;
                    end
                    m_lsu_v = 1;
                end else if (m_lsu_v && lsu_rsp_ready) begin
                    m_lsu_v = 0;
                end
                if (i_acc) begin
                    m_ifu_v   = 1;
                    m_ifu_err = !i_al;
                    m_ifu_d   = i_al ? golden[int'(ifu_cmd_addr / 4)] : '0;
                end else if (m_ifu_v && ifu_rsp_ready) begin
                    m_ifu_v = 0;
                end
                if (l_acc) m_nohold = 1;
                else if (i_acc && i_al) m_nohold = 0;
            end
        end
    end

    initial begin
        repeat (3000) @(posedge clk);
        $display("FAIL watchdog: got timeout expected test end");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        ifu_cmd_valid = 1'b0;
        lsu_cmd_valid = 1'b0;
        ifu_rsp_ready = 1'b1;
        lsu_rsp_ready = 1'b1;
        repeat (n) tick();
    endtask

    initial begin
        tick();
        tick();
        #1;
        check("rst_ifu_rsp_valid", ifu_rsp_valid, 1'b0);
        check("rst_lsu_rsp_valid", lsu_rsp_valid, 1'b0);
        check("rst_nohold", itcm_nohold, 1'b1);
        check("rst_ram_cs", ram_cs, 1'b0);
        check("rst_ifu_rdata", ifu_rsp_rdata, 32'h0);
        check("rst_lsu_rdata", lsu_rsp_rdata, 32'h0);
        check("rst_ifu_err", ifu_rsp_err, 1'b0);
        check("rst_ifu_cmd_ready", ifu_cmd_ready, 1'b1);
        check("rst_lsu_cmd_ready", lsu_cmd_ready, 1'b1);
        rst = 1'b0;
        idle(1);

        // Aligned IFU fetch of 0x0010
        ifu_cmd_valid = 1'b1; ifu_cmd_addr = 16'h0010;
        #1;
        check("f10_ram_cs", ram_cs, 1'b1);
        check("f10_ram_addr", ram_addr, 14'h0004);
        check("f10_ifu_cmd_ready", ifu_cmd_ready, 1'b1);
        tick();
        ifu_cmd_valid = 1'b0;
        #1;
        check("f10_rsp_valid", ifu_rsp_valid, 1'b1);
        check("f10_rsp_rdata", ifu_rsp_rdata, 32'h1000_0010);
        check("f10_nohold", itcm_nohold, 1'b0);
        idle(1);

        // Back-to-back IFU fetches, one per cycle
        for (int i = 0; i < 4; i++) begin
            ifu_cmd_valid = 1'b1; ifu_cmd_addr = AW'(16'h0100 + 4 * i);
            #1;
            check("b2b_ifu_cmd_ready", ifu_cmd_ready, 1'b1);
            tick();
        end
        ifu_cmd_valid = 1'b0;
        #1;
        check("b2b_last_rdata", ifu_rsp_rdata, 32'h1000_010C);
        idle(1);

        // LSU full-word write, then IFU fetch of the same word
        lsu_cmd_valid = 1'b1; lsu_cmd_read = 1'b0; lsu_cmd_addr = 16'h0008;
        lsu_cmd_wdata = 32'hDEAD_BEEF; lsu_cmd_wmask = 4'hF;
        #1;
        check("wr_ram_we", ram_we, 1'b1);
        check("wr_ram_wem", ram_wem, 4'hF);
        check("wr_ram_addr", ram_addr, 14'h0002);
        tick();
        lsu_cmd_valid = 1'b0;
        ifu_cmd_valid = 1'b1; ifu_cmd_addr = 16'h0008;
        #1;
        check("wr_lsu_rsp_valid", lsu_rsp_valid, 1'b1);
        check("wr_lsu_rdata", lsu_rsp_rdata, 32'h0);
        check("wr_lsu_err", lsu_rsp_err, 1'b0);
        check("wr_nohold", itcm_nohold, 1'b1);
        tick();
        ifu_cmd_valid = 1'b0;
        #1;
        check("rb_ifu_rdata", ifu_rsp_rdata, 32'hDEAD_BEEF);
        check("rb_ifu_err", ifu_rsp_err, 1'b0);
        idle(1);

        // Partial write to word 3, then LSU read back
        lsu_cmd_valid = 1'b1; lsu_cmd_read = 1'b0; lsu_cmd_addr = 16'h000C;
        lsu_cmd_wdata = 32'h1122_3344; lsu_cmd_wmask = 4'b0101;
        tick();
        lsu_cmd_read = 1'b1;
        tick();
        lsu_cmd_valid = 1'b0;
        #1;
        check("pw_lsu_rdata", lsu_rsp_rdata, 32'h1022_0044);
        idle(1);

        // Simultaneous requests: LSU wins, IFU served next cycle
        lsu_cmd_valid = 1'b1; lsu_cmd_read = 1'b1; lsu_cmd_addr = 16'h0018;
        ifu_cmd_valid = 1'b1; ifu_cmd_addr = 16'h0014;
        #1;
        check("arb_lsu_cmd_ready", lsu_cmd_ready, 1'b1);
        check("arb_ifu_cmd_ready", ifu_cmd_ready, 1'b0);
        tick();
        lsu_cmd_valid = 1'b0;
        #1;
        check("arb_ifu_next_ready", ifu_cmd_ready, 1'b1);
        check("arb_ifu_ram_addr", ram_addr, 14'h0005);
        check("arb_lsu_rdata", lsu_rsp_rdata, 32'h1000_0018);
        tick();
        ifu_cmd_valid = 1'b0;
        #1;
        check("arb_ifu_rdata", ifu_rsp_rdata, 32'h1000_0014);
        idle(1);

        // IFU response stalled three cycles while LSU reads other words
        ifu_rsp_ready = 1'b0;
        ifu_cmd_valid = 1'b1; ifu_cmd_addr = 16'h0020;
        tick();
        ifu_cmd_addr = 16'h0024;
        lsu_cmd_valid = 1'b1; lsu_cmd_read = 1'b1; lsu_cmd_addr = 16'h0040;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_ifu_rdata", ifu_rsp_rdata, 32'h1000_0020);
            check("stall_ifu_cmd_ready", ifu_cmd_ready, 1'b0);
            tick();
            lsu_cmd_addr = AW'(16'h0044 + 4 * i);
        end
        lsu_cmd_valid = 1'b0;
        ifu_rsp_ready = 1'b1;
        #1;
        check("stall_fire_cmd_ready", ifu_cmd_ready, 1'b1);
        check("stall_fire_rdata", ifu_rsp_rdata, 32'h1000_0020);
        tick();
        ifu_cmd_valid = 1'b0;
        #1;
        check("stall_next_rdata", ifu_rsp_rdata, 32'h1000_0024);
        idle(1);

        // Misaligned IFU fetch
        ifu_cmd_valid = 1'b1; ifu_cmd_addr = 16'h0002;
        #1;
        check("mis_ram_cs", ram_cs, 1'b0);
        check("mis_ifu_cmd_ready", ifu_cmd_ready, 1'b1);
        tick();
        ifu_cmd_valid = 1'b0;
        #1;
        check("mis_rsp_valid", ifu_rsp_valid, 1'b1);
        check("mis_rsp_err", ifu_rsp_err, 1'b1);
        check("mis_rsp_rdata", ifu_rsp_rdata, 32'h0);
        idle(1);

        // Reset while an IFU response is stalled
        ifu_rsp_ready = 1'b0;
        ifu_cmd_valid = 1'b1; ifu_cmd_addr = 16'h0030;
        tick();
        ifu_cmd_valid = 1'b0;
        #1;
        check("rr_pre_valid", ifu_rsp_valid, 1'b1);
        check("rr_pre_nohold", itcm_nohold, 1'b0);
        rst = 1'b1;
        tick();
        #1;
        check("rr_valid", ifu_rsp_valid, 1'b0);
        check("rr_nohold", itcm_nohold, 1'b1);
        rst = 1'b0;
        ifu_rsp_ready = 1'b1;
        tick();
        #1;
        check("rr_no_stale_rsp", ifu_rsp_valid, 1'b0);
        ifu_cmd_valid = 1'b1; ifu_cmd_addr = 16'h0034;
        tick();
        ifu_cmd_valid = 1'b0;
        #1;
        check("rr_recover_rdata", ifu_rsp_rdata, 32'h1000_0034);
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
